// File: rtl/rat_ckpt_if.sv
// Bus bundle for the checkpointed register alias table: rename, wakeup and
// checkpoint-control strobes in, current map and checkpoint status out.
interface rat_ckpt_if #(
    parameter int NUM_LRS    = 10,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RENAME = 2,
    parameter int NUM_WB     = 2,
    parameter int NUM_CKPT   = 4
);
    localparam int LR_W = $clog2(NUM_LRS);
    localparam int CP_W = $clog2(NUM_CKPT);

    logic [NUM_RENAME-1:0]            rename_valid;
    logic [NUM_RENAME*LR_W-1:0]       rename_lr;
    logic [NUM_RENAME*ADDR_WIDTH-1:0] rename_pr;
    logic [NUM_WB-1:0]                wb_valid;
    logic [NUM_WB*ADDR_WIDTH-1:0]     wb_pr;
    logic                             ckpt_take;
    logic                             ckpt_release;
    logic                             restore_valid;
    logic [CP_W-1:0]                  restore_id;
    logic [NUM_LRS*ADDR_WIDTH-1:0]    assignments;
    logic [NUM_LRS-1:0]               done_flags;
    logic [CP_W-1:0]                  ckpt_id;
    logic                             ckpt_full;
    logic [CP_W:0]                    ckpt_count;

    modport slave (
        input  rename_valid, rename_lr, rename_pr, wb_valid, wb_pr,
        input  ckpt_take, ckpt_release, restore_valid, restore_id,
        output assignments, done_flags, ckpt_id, ckpt_full, ckpt_count
    );

    modport master (
        output rename_valid, rename_lr, rename_pr, wb_valid, wb_pr,
        output ckpt_take, ckpt_release, restore_valid, restore_id,
        input  assignments, done_flags, ckpt_id, ckpt_full, ckpt_count
    );
endinterface

// File: rtl/rat_ckpt.sv
// Multi-port register alias table with a circular stack of branch checkpoints
// that can be restored in a single cycle on a mispredict.
module rat_ckpt #(
    parameter int NUM_LRS    = 10,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RENAME = 2,
    parameter int NUM_WB     = 2,
    parameter int NUM_CKPT   = 4
) (
    input logic         clk,
    input logic         rst,
    rat_ckpt_if.slave   bus
);
    localparam int LR_W = $clog2(NUM_LRS);
    localparam int CP_W = $clog2(NUM_CKPT);

    typedef logic [ADDR_WIDTH-1:0] tag_t;

    // Handshake: every input is a single-cycle strobe with no ready/backpressure;
    // it is accepted on the clock edge where it is high, and silently dropped
    // when illegal (take while full, release while empty, restore out of range).

    tag_t               map_q [NUM_LRS];
    tag_t               map_n [NUM_LRS];
    logic [NUM_LRS-1:0] done_q, done_n;

    tag_t               snap_map    [NUM_CKPT][NUM_LRS];
    logic [NUM_LRS-1:0] snap_done   [NUM_CKPT];
    logic [NUM_LRS-1:0] snap_done_n [NUM_CKPT];

    logic [CP_W-1:0] head_q, head_n, tail_q, tail_n, rs_off;
    logic [CP_W:0]   count_q, count_n;
    logic            full, restore_ok, take_ok, rel_ok;

    function automatic logic wb_hit(input tag_t t,
                                    input logic [NUM_WB-1:0] v,
                                    input logic [NUM_WB*ADDR_WIDTH-1:0] prs);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (v[k] && (prs[k*ADDR_WIDTH +: ADDR_WIDTH] == t)) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        full       = (count_q == (CP_W+1)'(NUM_CKPT));
        rel_ok     = bus.ckpt_release && (count_q != '0);
        rs_off     = bus.restore_id - head_q;
        // Offset from head below count means the slot is live, which also covers the full case.
        restore_ok = bus.restore_valid && ({1'b0, rs_off} < count_q);
        take_ok    = bus.ckpt_take && !full && !restore_ok;

        for (int s = 0; s < NUM_CKPT; s++) begin
            for (int i = 0; i < NUM_LRS; i++) begin
                snap_done_n[s][i] = snap_done[s][i] | wb_hit(snap_map[s][i], bus.wb_valid, bus.wb_pr);
            end
        end

        map_n  = map_q;
        done_n = done_q;
        if (restore_ok) begin
            map_n  = snap_map[bus.restore_id];
            done_n = snap_done_n[bus.restore_id];
        end else begin
            for (int i = 0; i < NUM_LRS; i++) begin
                done_n[i] = done_q[i] | wb_hit(map_q[i], bus.wb_valid, bus.wb_pr);
            end
            // Ascending port order so a later port wins; out-of-range LRs never match.
            for (int k = 0; k < NUM_RENAME; k++) begin
                for (int i = 0; i < NUM_LRS; i++) begin
                    if (bus.rename_valid[k] && (bus.rename_lr[k*LR_W +: LR_W] == LR_W'(i))) begin
                        map_n[i]  = bus.rename_pr[k*ADDR_WIDTH +: ADDR_WIDTH];
                        done_n[i] = 1'b0;
                    end
                end
            end
        end

        head_n = head_q + CP_W'(rel_ok);
        if (restore_ok) begin
            tail_n  = bus.restore_id;
            count_n = {1'b0, bus.restore_id - head_n};
        end else begin
            tail_n  = tail_q + CP_W'(take_ok);
            count_n = count_q + (CP_W+1)'(take_ok) - (CP_W+1)'(rel_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_LRS; i++) map_q[i] <= ADDR_WIDTH'(i + 2);
            done_q  <= '1;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            map_q   <= map_n;
            done_q  <= done_n;
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= count_n;
        end
    end

    // Snapshot storage needs no reset; stale slots are never restorable.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_CKPT; s++) begin
            if (take_ok && (tail_q == CP_W'(s))) begin
                snap_map[s]  <= map_n;
                snap_done[s] <= done_n;
            end else begin
                snap_done[s] <= snap_done_n[s];
            end
        end
    end

    always_comb begin
        bus.assignments = '0;
        for (int i = 0; i < NUM_LRS; i++) begin
            bus.assignments[i*ADDR_WIDTH +: ADDR_WIDTH] = map_q[i];
        end
    end

    assign bus.done_flags = done_q;
    assign bus.ckpt_id    = tail_q;
    assign bus.ckpt_full  = full;
    assign bus.ckpt_count = count_q;
endmodule

// File: tb/tb_rat_ckpt.sv
// Directed table-driven bench for rat_ckpt: one vector per cycle with
// hand-computed expected map entry, done flags and checkpoint status.
module tb_rat_ckpt;
  localparam int NUM_LRS    = 10;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_RENAME = 2;
  localparam int NUM_WB     = 2;
  localparam int NUM_CKPT   = 4;
  localparam int EW         = 5 + 10 + 3 + 2 + 1;

  typedef struct {
    logic       rst_n;
    logic [1:0] rv;
    logic [3:0] lr0, lr1;
    logic [4:0] pr0, pr1;
    logic [1:0] wv;
    logic [4:0] w0, w1;
    logic       take, rel, rsv;
    logic [1:0] rsid;
    logic [3:0] clr;
    logic [4:0] etag;
    logic [9:0] edone;
    logic [2:0] ecnt;
    logic [1:0] eid;
    logic       efull;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rat_ckpt_if #(.NUM_LRS(NUM_LRS), .ADDR_WIDTH(ADDR_WIDTH), .NUM_RENAME(NUM_RENAME),
                .NUM_WB(NUM_WB), .NUM_CKPT(NUM_CKPT)) bus ();

  rat_ckpt #(.NUM_LRS(NUM_LRS), .ADDR_WIDTH(ADDR_WIDTH), .NUM_RENAME(NUM_RENAME),
             .NUM_WB(NUM_WB), .NUM_CKPT(NUM_CKPT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  vec_t tbl[$];
  logic [EW-1:0] exp_q[$];
  logic [NUM_LRS*ADDR_WIDTH-1:0] reset_map;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t ev(input int clr, input int etag, input logic [9:0] edone,
                              input int ecnt, input int eid, input logic efull);
    vec_t v;
    v.rst_n = 1'b1; v.rv = '0; v.lr0 = '0; v.lr1 = '0; v.pr0 = '0; v.pr1 = '0;
    v.wv = '0; v.w0 = '0; v.w1 = '0; v.take = 1'b0; v.rel = 1'b0; v.rsv = 1'b0;
    v.rsid = '0; v.clr = 4'(clr); v.etag = 5'(etag); v.edone = edone;
    v.ecnt = 3'(ecnt); v.eid = 2'(eid); v.efull = efull;
    return v;
  endfunction

  task automatic drive_idle();
    bus.rename_valid = '0; bus.rename_lr = '0; bus.rename_pr = '0;
    bus.wb_valid = '0; bus.wb_pr = '0;
    bus.ckpt_take = 1'b0; bus.ckpt_release = 1'b0;
    bus.restore_valid = 1'b0; bus.restore_id = '0;
  endtask

  task automatic apply(input vec_t v);
    rst               = v.rst_n;
    bus.rename_valid  = v.rv;
    bus.rename_lr     = {v.lr1, v.lr0};
    bus.rename_pr     = {v.pr1, v.pr0};
    bus.wb_valid      = v.wv;
    bus.wb_pr         = {v.w1, v.w0};
    bus.ckpt_take     = v.take;
    bus.ckpt_release  = v.rel;
    bus.restore_valid = v.rsv;
    bus.restore_id    = v.rsid;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic [9:0] edone,
                              input int ecnt, input int eid, input logic efull);
    check({tag, " done_flags"}, 64'(bus.done_flags), 64'(edone));
    check({tag, " ckpt_count"}, 64'(bus.ckpt_count), 64'(ecnt));
    check({tag, " ckpt_id"},    64'(bus.ckpt_id),    64'(eid));
    check({tag, " ckpt_full"},  64'(bus.ckpt_full),  64'(efull));
  endtask

  initial begin
    vec_t v;
    logic [EW-1:0] e;

    for (int i = 0; i < NUM_LRS; i++) reset_map[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(i + 2);

    // Reset then idle.
    drive_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset assignments", 64'(bus.assignments), 64'(reset_map));
    check_status("reset", 10'h3FF, 0, 0, 1'b0);

    // Dual rename, same LR: port1 wins.
    v = ev(3, 21, 10'h3F7, 0, 0, 0); v.rv = 2'b11; v.lr0 = 3; v.pr0 = 20; v.lr1 = 3; v.pr1 = 21; tbl.push_back(v);
    v = ev(4, 6, 10'h3F7, 0, 0, 0); tbl.push_back(v);
    // Rename LR1, then wake it while renaming LR2 to a tag woken in the same cycle.
    v = ev(1, 17, 10'h3F5, 0, 0, 0); v.rv = 2'b01; v.lr0 = 1; v.pr0 = 17; tbl.push_back(v);
    v = ev(2, 18, 10'h3F3, 0, 0, 0); v.rv = 2'b01; v.lr0 = 2; v.pr0 = 18;
    v.wv = 2'b11; v.w0 = 17; v.w1 = 18; tbl.push_back(v);
    v = ev(1, 17, 10'h3F3, 0, 0, 0); tbl.push_back(v);
    v = ev(2, 18, 10'h3F7, 0, 0, 0); v.wv = 2'b10; v.w1 = 18; tbl.push_back(v);
    // Checkpoint, rename past it, wake the snapshot's tag, restore.
    v = ev(0, 12, 10'h3F6, 0, 0, 0); v.rv = 2'b01; v.lr0 = 0; v.pr0 = 12; tbl.push_back(v);
    v = ev(0, 12, 10'h3F6, 1, 1, 0); v.take = 1'b1; tbl.push_back(v);
    v = ev(0, 13, 10'h3F6, 1, 1, 0); v.rv = 2'b10; v.lr1 = 0; v.pr1 = 13; tbl.push_back(v);
    v = ev(0, 13, 10'h3F6, 1, 1, 0); v.wv = 2'b01; v.w0 = 12; tbl.push_back(v);
    v = ev(0, 12, 10'h3F7, 0, 0, 0); v.rsv = 1'b1; v.rsid = 0; tbl.push_back(v);
    // Fill, overfill, release, take+release with tail wrap.
    v = ev(0, 12, 10'h3F7, 1, 1, 0); v.take = 1'b1; tbl.push_back(v);
    v = ev(0, 12, 10'h3F7, 2, 2, 0); v.take = 1'b1; tbl.push_back(v);
    v = ev(0, 12, 10'h3F7, 3, 3, 0); v.take = 1'b1; tbl.push_back(v);
    v = ev(0, 12, 10'h3F7, 4, 0, 1); v.take = 1'b1; tbl.push_back(v);
    v = ev(0, 12, 10'h3F7, 4, 0, 1); v.take = 1'b1; tbl.push_back(v);
    v = ev(0, 12, 10'h3F7, 3, 0, 0); v.rel = 1'b1; tbl.push_back(v);
    v = ev(0, 12, 10'h3F7, 3, 1, 0); v.take = 1'b1; v.rel = 1'b1; tbl.push_back(v);
    // Reset overrides a same-cycle rename and take.
    v = ev(5, 7, 10'h3FF, 0, 0, 0); v.rst_n = 1'b0; v.rv = 2'b01; v.lr0 = 5; v.pr0 = 30; v.take = 1'b1; tbl.push_back(v);
    // Three takes, each capturing a different LR4 tag.
    v = ev(4, 25, 10'h3EF, 1, 1, 0); v.take = 1'b1; v.rv = 2'b01; v.lr0 = 4; v.pr0 = 25; tbl.push_back(v);
    v = ev(4, 26, 10'h3EF, 2, 2, 0); v.take = 1'b1; v.rv = 2'b01; v.lr0 = 4; v.pr0 = 26; tbl.push_back(v);
    v = ev(4, 27, 10'h3EF, 3, 3, 0); v.take = 1'b1; v.rv = 2'b01; v.lr0 = 4; v.pr0 = 27; tbl.push_back(v);
    v = ev(4, 28, 10'h3EF, 3, 3, 0); v.rv = 2'b01; v.lr0 = 4; v.pr0 = 28; tbl.push_back(v);
    // Restore slot 1; the same-cycle rename of LR5 must be dropped.
    v = ev(4, 26, 10'h3EF, 1, 1, 0); v.rsv = 1'b1; v.rsid = 1; v.rv = 2'b01; v.lr0 = 5; v.pr0 = 29; tbl.push_back(v);
    v = ev(5, 7, 10'h3EF, 1, 1, 0); tbl.push_back(v);
    v = ev(4, 26, 10'h3EF, 1, 1, 0); v.rsv = 1'b1; v.rsid = 3; tbl.push_back(v);
    v = ev(4, 26, 10'h3FF, 1, 1, 0); v.wv = 2'b01; v.w0 = 26; tbl.push_back(v);
    v = ev(4, 25, 10'h3EF, 0, 0, 0); v.rsv = 1'b1; v.rsid = 0; tbl.push_back(v);
    // Out-of-range LR on port0 ignored, port1 applies.
    v = ev(5, 30, 10'h3CF, 0, 0, 0); v.rv = 2'b11; v.lr0 = 12; v.pr0 = 31; v.lr1 = 5; v.pr1 = 30; tbl.push_back(v);
    v = ev(5, 30, 10'h3CF, 1, 1, 0); v.take = 1'b1; tbl.push_back(v);
    v = ev(5, 30, 10'h3CF, 2, 2, 0); v.take = 1'b1; tbl.push_back(v);
    v = ev(5, 30, 10'h3CF, 3, 3, 0); v.take = 1'b1; tbl.push_back(v);
    // Release and restore together: head advances first.
    v = ev(5, 30, 10'h3CF, 1, 2, 0); v.rel = 1'b1; v.rsv = 1'b1; v.rsid = 2; tbl.push_back(v);

    foreach (tbl[n]) exp_q.push_back({tbl[n].etag, tbl[n].edone, tbl[n].ecnt, tbl[n].eid, tbl[n].efull});

    foreach (tbl[n]) begin
      apply(tbl[n]);
      e = exp_q.pop_front();
      check($sformatf("row%0d lr%0d tag", n, tbl[n].clr),
            64'(bus.assignments[int'(tbl[n].clr)*ADDR_WIDTH +: ADDR_WIDTH]), 64'(e[20:16]));
      check_status($sformatf("row%0d", n), e[15:6], int'(e[5:3]), int'(e[2:1]), e[0]);
    end

    // Check the whole map is untouched apart from renamed LRs after a dual rename.
    v = ev(0, 0, 10'h3FF, 0, 0, 0); v.rst_n = 1'b0; apply(v);
    v = ev(0, 0, 10'h3F7, 0, 0, 0); v.rv = 2'b11; v.lr0 = 3; v.pr0 = 20; v.lr1 = 3; v.pr1 = 21; apply(v);
    begin
      logic [NUM_LRS*ADDR_WIDTH-1:0] m;
      m = reset_map;
      m[3*ADDR_WIDTH +: ADDR_WIDTH] = 5'd21;
      check("dual rename full map", 64'(bus.assignments), 64'(m));
    end

    // Mid-sequence reset with live checkpoints and competing strobes.
    v = ev(0, 0, 10'h3FF, 0, 0, 0); v.take = 1'b1; apply(v); apply(v);
    v.rst_n = 1'b0; v.rv = 2'b01; v.lr0 = 7; v.pr0 = 3; v.rel = 1'b1; apply(v);
    check("mid reset map", 64'(bus.assignments), 64'(reset_map));
    check_status("mid reset", 10'h3FF, 0, 0, 1'b0);

    drive_idle();
    rst = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rat_ckpt.md
Name: rat_ckpt

Overview:
Multi-port register alias table with branch checkpointing for the out-of-order 6502 core. It maps each logical register (LR) to a physical tag and tracks a per-LR done flag. It accepts several renames and writeback wakeups per cycle. It holds a circular stack of snapshots that can be restored in one cycle on a mispredict. It sits between decode/rename and dispatch, and replaces the single-write RAT.

Parameters:
NUM_LRS, 10, number of logical registers
ADDR_WIDTH, 5, physical tag width
NUM_RENAME, 2, rename ports per cycle
NUM_WB, 2, writeback/wakeup ports per cycle
NUM_CKPT, 4, checkpoint slots; must be a power of 2
(local) LR_W = $clog2(NUM_LRS); CP_W = $clog2(NUM_CKPT)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0)
rename_valid  in  NUM_RENAME  per-port rename strobe
rename_lr  in  NUM_RENAME*LR_W  LR being renamed, port k at [k*LR_W +: LR_W]
rename_pr  in  NUM_RENAME*ADDR_WIDTH  new physical tag per port
wb_valid  in  NUM_WB  per-port wakeup strobe
wb_pr  in  NUM_WB*ADDR_WIDTH  completed physical tag per port
ckpt_take  in  1  snapshot request
ckpt_release  in  1  free oldest checkpoint (branch resolved correct)
restore_valid  in  1  mispredict recovery
restore_id  in  CP_W  checkpoint to restore
assignments  out  NUM_LRS*ADDR_WIDTH  current map, LR i at [i*ADDR_WIDTH +: ADDR_WIDTH]
done_flags  out  NUM_LRS  1 = LR's current tag has its value ready
ckpt_id  out  CP_W  slot a ckpt_take this cycle will use (tail pointer)
ckpt_full  out  1  count == NUM_CKPT
ckpt_count  out  CP_W+1  occupied slots

Behaviour:
- All outputs are registered, except that ckpt_id and ckpt_full are decoded from registers. State updates are visible the cycle after the strobe.
- Reset (rst==0 at posedge): LR i maps to tag i+2; done_flags all 1; head=tail=count=0. Snapshot contents are don't-care. Reset overrides every other input in the same cycle.
- Per-cycle priority, evaluated in this order:
  1. Wakeup. For each LR whose registered tag equals any valid wb_pr, done_next=1. The same rule applies to every stored snapshot's done bits, so snapshots stay current.
  2. Rename. Ports are applied in ascending order. Each sets assignments[lr]=pr and done[lr]=0. A later port wins on the same LR. Rename overrides wakeup for that LR in the same cycle, because the new tag is never ready.
  3. Take. If ckpt_take && !ckpt_full, slot[tail] <= next-state map and done flags after steps 1 and 2. Then tail++ (mod NUM_CKPT) and count++. A take while full is ignored with no state change.
  4. Release. If ckpt_release && count!=0, head++ and count--. A release while empty is ignored.
- Take and release in the same cycle: both apply, and count is unchanged.
- Restore:
  - Valid only when restore_id lies within [head, tail) modulo NUM_CKPT. Otherwise restore is ignored entirely.
  - Map and done flags load from slot[restore_id], with same-cycle wakeups applied on top.
  - Rename and take in that cycle are ignored.
  - tail <= restore_id; count <= (restore_id - head) mod NUM_CKPT. This frees the restored slot and all younger slots.
  - A release in the same cycle still advances head first. Restoring the slot being released is illegal; behaviour is undefined and it is not driven.
- Pointers wrap modulo NUM_CKPT. count distinguishes full from empty when head==tail.
- Tag compares use the full ADDR_WIDTH. Duplicate wb_pr values across ports are harmless.
- rename_lr >= NUM_LRS: the port is ignored.

Test Plan:
- Reset then idle: assignments = {11,10,...,3,2} (LR9..LR0), done_flags=10'h3FF, ckpt_count=0, ckpt_full=0, ckpt_id=0.
- Same-cycle dual rename: port0 LR3->20 and port1 LR3->21 -> LR3=21, done[3]=0; other LRs unchanged.
- Rename LR1->17; next cycle wb_pr=17 -> done[1]=1. In the same cycle rename LR2->18 with wb_pr=18 -> LR2=18, done[2]=0.
- Rename LR0->12; take (ckpt_id 0); rename LR0->13; wb_pr=12. Then restore_id=0 -> LR0=12, done[0]=1, ckpt_count=0, ckpt_id=0.
- Take 4 times -> ckpt_full=1, count=4. A 5th take is ignored. Release -> count=3, full=0. Take+release together -> count stays 3. tail wraps 3->0.
- Three takes (slots 0,1,2). Restore_id=1 with a rename in the same cycle -> rename dropped, map = slot1, count=1, ckpt_id=1. restore_id=3 (invalid) -> no change. Drive rst=0 mid-sequence -> full reset state next cycle.
